bth_mlt_arb: RTL and testbench
==============================

// Module: bth_mlt_arb
// PURPOSE
//  Shares one sequential radix-2 Booth multiplier engine between NREQ requesters.
//  Round-robin arbitration; accepts one signed operand pair via valid/ready and runs
//  WIDTH Booth iterations. Returns the signed 2*WIDTH product tagged with the requester id.
//  Sits between the client blocks and the multiplier; it is the only driver of the engine's load.
// PARAMETERS
//  WIDTH  4  operand width in bits; product is 2*WIDTH, two's complement
//  NREQ   4  number of requesters, >=2
//  IDW    2  requester id width, = clog2(NREQ)
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             asynchronous, active-high reset
//  req_valid  in   NREQ          per-requester request valid
//  req_q      in   NREQ*WIDTH    multiplier operands, slice i = requester i
//  req_m      in   NREQ*WIDTH    multiplicand operands, slice i = requester i
//  req_ready  out  NREQ          one-hot accept strobe
//  rsp_valid  out  1             result available
//  rsp_ready  in   1             consumer takes result
//  rsp_id     out  IDW           requester index of the result
//  rsp_prod   out  2*WIDTH       signed product q*m
//  busy       out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0, cnt=0, ptr=NREQ-1.
//   Reset also resets the engine.
//  Reset mid-operation: the in-flight request is discarded, with no response.
//   After reset release, requester 0 has the highest priority.
//  FSM states: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  IDLE: if any req_valid is high, compute grant g = first valid index searching ptr+1, ptr+2, ...
//   The search wraps modulo NREQ. req_ready[g]=1 combinationally in that cycle (only in IDLE).
//   On the clock edge: capture req_q[g], req_m[g] and g; set ptr<=g; go to LOAD.
//  LOAD: engine load=1 for exactly one cycle; the engine clears its accumulator and q_1. Set cnt<=WIDTH.
//  RUN: one Booth iteration per cycle and cnt decrements. When cnt reaches 1, go to DONE on the next edge.
//  DONE: rsp_valid=1; rsp_prod and rsp_id are registered and held stable until rsp_ready=1.
//   Transfer happens on the edge where rsp_valid&&rsp_ready; then go to IDLE. No new accept occurs in DONE.
//  Latency: accept at cycle T -> rsp_valid at T+WIDTH+2.
//   Minimum issue interval is WIDTH+3 cycles (rsp_ready held high).
//  Handshake rules:
//   - Requesters hold req_valid and operands stable until they see req_ready.
//   - Requesters must not make req_valid depend on req_ready.
//   - Dropping req_valid before grant is legal; that requester is simply not granted.
//  Arithmetic:
//   - Operands and the product are two's complement.
//   - -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2W-2) exactly; no overflow is possible in 2*WIDTH bits.
//  Simultaneous requests: exactly one grant per accept.
//   A requester that keeps requesting waits at most NREQ-1 other grants.
//  Backpressure: rsp_ready=0 holds DONE indefinitely; req_ready stays 0 throughout.
//  Unused requester slices are ignored; X on non-granted operand slices must not propagate.
// STRUCTURE
//  Shared package bth_mlt_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2, ST_DONE=2'd3
//   - clog2 function used to derive IDW
//  Sub-module booth_core #(WIDTH):
//   - ports clk, rst, load, step, q, m, prod
//   - load clears A and q_1 and loads Q and M; step performs one arithmetic-shift Booth iteration
//   - reuses add_sub_gen for the A+M and A-M paths
//  Arbiter, FSM and counter stay in the top module, each in its own always block.
// TESTING  (WIDTH=4, NREQ=4)
//  1. Reset mid-RUN: pulse rst during RUN of a request ->
//     rsp_valid=0 and busy=0 immediately (asynchronous); no response appears afterwards; ptr=3.
//  2. Single request 3*5:
//     - req_valid[2]=1 with q=3, m=5 -> req_ready[2]=1 at T
//     - at T+6: rsp_valid=1, rsp_prod=8'h0F, rsp_id=2
//  3. Signed corners:
//     - -8*-8 -> 8'h40
//     - 7*-8 -> 8'hC8
//     - -1*1 -> 8'hFF
//     - 0*-5 -> 8'h00
//  4. Fairness: all four req_valid held high, rsp_ready=1 ->
//     grants in order 0,1,2,3,0; the issue interval is exactly 7 cycles.
//  5. Backpressure: rsp_ready=0 for 10 cycles in DONE ->
//     rsp_prod and rsp_id stay stable, req_ready stays 0; the transfer completes on the first rsp_ready=1 edge.
//  6. Back-to-back accumulator hygiene: 7*7 immediately followed by 1*1 ->
//     rsp_prod values 8'h31 then 8'h01; no residue carries over from the previous operation.

Source files
------------

// File: rtl/bth_mlt_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM state encoding and a
// constant clog2 used to size id and counter fields.
package bth_mlt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_sub_gen.sv
// Generic two's complement adder/subtractor: y = a + b, or a - b when sub is set.
module add_sub_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/booth_core.sv
// Sequential radix-2 Booth engine: load initialises A, Q, q_1 and M; each step performs
// one add/subtract plus arithmetic shift right of {A, Q, q_1}.
module booth_core
  import bth_mlt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] prod
);

  // A carries one guard bit so A - M cannot overflow when M is the most negative value.
  logic [WIDTH:0]     acc, acc_nxt, mcand, sum, diff, acc_sel;
  logic [WIDTH-1:0]   mq, mq_nxt;
  logic               q_1, q_1_nxt;
  logic [2*WIDTH+1:0] shifted;

  add_sub_gen #(.WIDTH(WIDTH + 1)) u_add (
    .a   (acc),
    .b   (mcand),
    .sub (1'b0),
    .y   (sum)
  );

  add_sub_gen #(.WIDTH(WIDTH + 1)) u_sub (
    .a   (acc),
    .b   (mcand),
    .sub (1'b1),
    .y   (diff)
  );

  always_comb begin
    case ({mq[0], q_1})
      2'b01:   acc_sel = sum;
      2'b10:   acc_sel = diff;
      default: acc_sel = acc;
    endcase
    shifted = {acc_sel[WIDTH], acc_sel, mq};
    acc_nxt = acc;
    mq_nxt  = mq;
    q_1_nxt = q_1;
    if (load) begin
      acc_nxt = '0;
      mq_nxt  = q;
      q_1_nxt = 1'b0;
    end else if (step) begin
      acc_nxt = shifted[2*WIDTH+1:WIDTH+1];
      mq_nxt  = shifted[WIDTH:1];
      q_1_nxt = shifted[0];
    end
  end

  // Look-ahead product: the value the registers hold after this edge.
  assign prod = {acc_nxt[WIDTH-1:0], mq_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mq    <= '0;
      q_1   <= 1'b0;
      mcand <= '0;
    end else begin
      acc <= acc_nxt;
      mq  <= mq_nxt;
      q_1 <= q_1_nxt;
      if (load) mcand <= {m[WIDTH-1], m};
    end
  end

endmodule

// File: rtl/bth_mlt_arb.sv
// Round-robin arbiter sharing one sequential Booth multiplier between NREQ requesters;
// returns the signed 2*WIDTH product tagged with the requester id.
module bth_mlt_arb
  import bth_mlt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_q,
  input  logic [NREQ*WIDTH-1:0] req_m,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_prod,
  output logic                  busy
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_e             state;
  logic [IDW-1:0]     ptr, grant, cand;
  logic               any_valid;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   op_q, op_m;
  logic [2*WIDTH-1:0] eng_prod;

  // Search starts just after the last granted requester and wraps modulo NREQ.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && any_valid) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
      busy      <= 1'b0;
      op_q      <= '0;
      op_m      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            op_q  <= req_q[32'(grant)*WIDTH +: WIDTH];
            op_m  <= req_m[32'(grant)*WIDTH +: WIDTH];
            ptr   <= grant;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          if (cnt == CW'(1)) begin
            rsp_valid <= 1'b1;
            rsp_prod  <= eng_prod;
            rsp_id    <= ptr;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_LOAD) begin
      cnt <= CW'(WIDTH);
    end else if (state == ST_RUN) begin
      cnt <= cnt - 1'b1;
    end
  end

  booth_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_LOAD),
    .step (state == ST_RUN),
    .q    (op_q),
    .m    (op_m),
    .prod (eng_prod)
  );

endmodule

// File: tb/tb_bth_mlt_arb.sv
// Scoreboard bench for bth_mlt_arb: a negedge monitor models round-robin grant order,
// latency and signed products, while the stimulus process runs directed and random phases.
module tb_bth_mlt_arb;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_q = '0;
  logic [N*W-1:0] req_m = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_prod;
  logic           busy;

  bth_mlt_arb #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_q     (req_q),
    .req_m     (req_m),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] prod;
    int         due;
    bit         seen;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         m_ptr = N - 1;
  bit         m_busy = 1'b0;
  int         prev_acc = -1;
  bit         hold_all = 1'b0;
  logic [N-1:0] acc_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr(input int p, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] p;
    p = $signed({{4{a[3]}}, a}) * $signed({{4{b[3]}}, b});
    return p;
  endfunction

  // Monitor / reference model
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    exp_t e;
    acc_mask = '0;
    if (rst) begin
      sb.delete();
      m_ptr    = N - 1;
      m_busy   = 1'b0;
      prev_acc = -1;
    end else begin
      chk("busy", busy, m_busy);
      exp_rdy = '0;
      g = -1;
      if (!m_busy && req_valid != 0) begin
        g = rr(m_ptr, req_valid);
        exp_rdy = N'(1 << g);
      end
      chk("req_ready", req_ready, exp_rdy);
      if (g >= 0 && req_ready == exp_rdy) begin
        e.id   = g;
        e.prod = smul(req_q[g*W +: W], req_m[g*W +: W]);
        e.due  = cyc + W + 2;
        e.seen = 1'b0;
        sb.push_back(e);
        m_ptr    = g;
        m_busy   = 1'b1;
        acc_mask = exp_rdy;
        grant_log.push_back(g);
        if (hold_all && prev_acc >= 0) chk("issue_interval", cyc - prev_acc, W + 3);
        prev_acc = hold_all ? cyc : -1;
      end
      if (sb.size() == 0) begin
        chk("spurious_rsp_valid", rsp_valid, 1'b0);
      end else begin
        if (!sb[0].seen) begin
          if (cyc < sb[0].due) begin
            chk("early_rsp_valid", rsp_valid, 1'b0);
          end else begin
            chk("latency_rsp_valid", rsp_valid, 1'b1);
            sb[0].seen = 1'b1;
          end
        end
        if (rsp_valid) begin
          chk("rsp_id", rsp_id, sb[0].id);
          chk("rsp_prod", rsp_prod, sb[0].prod);
          if (rsp_ready) begin
            void'(sb.pop_front());
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [3:0] qv, input logic [3:0] mv);
    req_q[i*W +: W] = qv;
    req_m[i*W +: W] = mv;
  endtask

  task automatic issue(input int i, input logic [3:0] qv, input logic [3:0] mv);
    set_ops(i, qv, mv);
    req_valid[i] = 1'b1;
  endtask

  // Advance one cycle; accepted requesters drop valid, or re-request when hold_all is set.
  task automatic step_cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        if (hold_all) issue(i, 4'($urandom), 4'($urandom));
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && !m_busy && req_valid == 0) return;
      step_cyc();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for idle, got busy, expected idle", name);
  endtask

  task automatic wait_granted(input int i);
    for (int t = 0; t < 100; t++) begin
      if (!req_valid[i]) return;
      step_cyc();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL grant_wait: requester %0d got no grant, expected one", i);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_prod", rsp_prod, 8'h00);
    chk("reset_rsp_id", rsp_id, 2'd0);
    chk("reset_busy", busy, 1'b0);

    // Reset during RUN discards the request
    issue(1, 4'd5, 4'd3);
    repeat (4) step_cyc();
    rst = 1'b1;
    #1;
    chk("midrun_rsp_valid", rsp_valid, 1'b0);
    chk("midrun_busy", busy, 1'b0);
    step_cyc();
    rst = 1'b0;
    repeat (10) step_cyc();

    // Fairness: ptr is back at NREQ-1, so 0 wins first
    grant_log.delete();
    for (int i = 0; i < N; i++) set_ops(i, 4'($urandom), 4'($urandom));
    req_valid = '1;
    hold_all  = 1'b1;
    t = 0;
    while (grant_log.size() < 5 && t < 100) begin
      step_cyc();
      t++;
    end
    hold_all = 1'b0;
    chk("fair_count", (grant_log.size() >= 5), 1'b1);
    if (grant_log.size() >= 5) begin
      chk("fair_g0", grant_log[0], 0);
      chk("fair_g1", grant_log[1], 1);
      chk("fair_g2", grant_log[2], 2);
      chk("fair_g3", grant_log[3], 3);
      chk("fair_g4", grant_log[4], 0);
    end
    wait_idle("fairness");

    // Single 3*5 and signed corners
    issue(2, 4'd3, 4'd5);
    wait_idle("mul_3x5");
    issue(1, 4'h8, 4'h8);
    wait_idle("mul_m8xm8");
    issue(3, 4'h7, 4'h8);
    wait_idle("mul_7xm8");
    issue(0, 4'hF, 4'h1);
    wait_idle("mul_m1x1");
    issue(2, 4'h0, 4'hB);
    wait_idle("mul_0xm5");

    // Backpressure: hold DONE 10 cycles with another request pending
    rsp_ready = 1'b0;
    issue(3, 4'hD, 4'h5);
    t = 0;
    while (!rsp_valid && t < 20) begin
      step_cyc();
      t++;
    end
    chk("bp_reached_done", rsp_valid, 1'b1);
    issue(0, 4'h2, 4'h6);
    repeat (10) step_cyc();
    rsp_ready = 1'b1;
    wait_idle("backpressure");

    // Back-to-back: 7*7 then 1*1
    issue(0, 4'h7, 4'h7);
    wait_granted(0);
    issue(1, 4'h1, 4'h1);
    wait_idle("back_to_back");

    // Random phase
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0) issue(i, 4'($urandom), 4'($urandom));
        end else if ($urandom_range(31) == 0 && !acc_mask[i]) begin
          req_valid[i] = 1'b0;
        end
      end
      step_cyc();
    end
    rsp_ready = 1'b1;
    wait_idle("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
